// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor: pulses pll_rst, waits for a debounced lock with a bounded retry, then releases sys_reset.
// Optional build macro PLL_LOSS_COUNT_EN adds a saturating lock-loss counter (loss_cnt, loss_clr).
module pll_lock_supervisor #(
  parameter int RST_PULSE    = 16,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRY    = 3
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked_in,
  input  logic        relock_req,
`ifdef PLL_LOSS_COUNT_EN
  input  logic        loss_clr,
  output logic [15:0] loss_cnt,
`endif
  output logic        pll_rst,
  output logic        sys_reset,
  output logic        ready,
  output logic        fail,
  output logic [3:0]  retry_cnt
);

  localparam int MAXC = (RST_PULSE > LOCK_TIMEOUT)
                      ? ((RST_PULSE > LOCK_STABLE) ? RST_PULSE : LOCK_STABLE)
                      : ((LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE);
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] C_PULSE = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] C_TMO   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] C_STB   = CW'(LOCK_STABLE - 1);
  localparam logic [3:0]    R_MAX   = 4'(MAX_RETRY);

  typedef enum logic [2:0] {S_RESET, S_WAIT, S_STABLE, S_RUN, S_FAIL} state_t;

  state_t          state, nstate;
  logic [CW-1:0]   cnt, ncnt;
  logic [3:0]      nretry;
  logic [1:0]      sync_q;
  logic            locked_s;

  assign locked_s = sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], locked_in};
  end

  always_comb begin
    nstate = state;
    nretry = retry_cnt;
    case (state)
      S_RESET:  if (cnt == C_PULSE) nstate = S_WAIT;
      S_WAIT: begin
        // Lock is checked first so it beats a same-cycle timeout.
        if (locked_s) nstate = S_STABLE;
        else if (cnt == C_TMO) begin
          if (retry_cnt >= R_MAX) nstate = S_FAIL;
          else begin
            nretry = retry_cnt + 4'd1;
            nstate = S_RESET;
          end
        end
      end
      S_STABLE: begin
        if (!locked_s)          nstate = S_WAIT;
        else if (cnt == C_STB)  nstate = S_RUN;
      end
      S_RUN: begin
        if (!locked_s || relock_req) begin
          nstate = S_RESET;
          nretry = 4'd0;
        end
      end
      S_FAIL: begin
        if (relock_req) begin
          nstate = S_RESET;
          nretry = 4'd0;
        end
      end
      default: nstate = S_RESET;
    endcase
    // RUN and FAIL have no timed exit, so the counter is parked there.
    if (nstate != state || state == S_RUN || state == S_FAIL) ncnt = '0;
    else                                                      ncnt = cnt + CW'(1);
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET;
      cnt       <= '0;
      retry_cnt <= 4'd0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= nstate;
      cnt       <= ncnt;
      retry_cnt <= nretry;
      pll_rst   <= (nstate == S_RESET) || (nstate == S_FAIL);
      sys_reset <= (nstate != S_RUN);
      ready     <= (nstate == S_RUN);
      fail      <= (nstate == S_FAIL);
    end
  end

`ifdef PLL_LOSS_COUNT_EN
  logic loss_evt;
  assign loss_evt = (state == S_RUN) && !locked_s;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst)                                 loss_cnt <= 16'h0000;
    else if (loss_clr)                       loss_cnt <= 16'h0000;
    else if (loss_evt && loss_cnt != 16'hFFFF) loss_cnt <= loss_cnt + 16'h0001;
  end
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized bench for pll_lock_supervisor; reference model tracks phases by absolute entry cycle.
module tb_pll_lock_supervisor;
  localparam int RP = 4, TO = 100, LS = 8, MR = 2;
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FAIL = 4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1, locked_in = 1'b0, relock_req = 1'b0, loss_clr = 1'b0;
  logic       pll_rst, sys_reset, ready, fail;
  logic [3:0] retry_cnt;
`ifdef PLL_LOSS_COUNT_EN
  logic [15:0] loss_cnt;
`endif

  always #5 refclk = ~refclk;

  pll_lock_supervisor #(.RST_PULSE(RP), .LOCK_TIMEOUT(TO), .LOCK_STABLE(LS), .MAX_RETRY(MR)) dut (
    .refclk(refclk), .rst(rst), .locked_in(locked_in), .relock_req(relock_req),
`ifdef PLL_LOSS_COUNT_EN
    .loss_clr(loss_clr), .loss_cnt(loss_cnt),
`endif
    .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .fail(fail), .retry_cnt(retry_cnt)
  );

  int n_chk = 0, n_pass = 0;
  int ph, t_ent, k = 0, m_retry, m_loss;
  bit q[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    ph = P_RST; t_ent = k; m_retry = 0; m_loss = 0;
    q.delete(); q.push_back(1'b0); q.push_back(1'b0);
  endtask

  // Model: locked_s is the input sampled two edges ago; phases end when
  // the time spent in them reaches the configured length.
  task automatic model_step();
    bit ls;
    int age, nph;
    ls = q.pop_front();
    q.push_back(locked_in);
    k++;
    age = k - t_ent;
    nph = ph;
    case (ph)
      P_RST:  if (age == RP) nph = P_WAIT;
      P_WAIT: if (ls) nph = P_STB;
              else if (age == TO) begin
                if (m_retry == MR) nph = P_FAIL;
                else begin m_retry++; nph = P_RST; end
              end
      P_STB:  if (!ls) nph = P_WAIT; else if (age == LS) nph = P_RUN;
      P_RUN:  if (!ls || relock_req) begin
                nph = P_RST; m_retry = 0;
                if (!ls && m_loss < 65535) m_loss++;
              end
      default: if (relock_req) begin nph = P_RST; m_retry = 0; end
    endcase
    if (loss_clr) m_loss = 0;
    if (nph != ph) t_ent = k;
    ph = nph;
  endtask

  task automatic check_all();
    chk("pll_rst", pll_rst, int'(ph == P_RST || ph == P_FAIL));
    chk("sys_reset", sys_reset, int'(ph != P_RUN));
    chk("ready", ready, int'(ph == P_RUN));
    chk("fail", fail, int'(ph == P_FAIL));
    chk("retry_cnt", retry_cnt, m_retry);
`ifdef PLL_LOSS_COUNT_EN
    chk("loss_cnt", loss_cnt, m_loss);
`endif
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst) model_reset(); else model_step();
    @(negedge refclk);
    check_all();
  endtask

  // Called at a negedge: raises rst between edges and checks the asynchronous effect.
  task automatic arst();
    #2 rst = 1'b1;
    #1;
    chk("arst_pll_rst", pll_rst, 1);
    chk("arst_sys_reset", sys_reset, 1);
    chk("arst_ready", ready, 0);
    chk("arst_fail", fail, 0);
    chk("arst_retry", retry_cnt, 0);
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int budget, output int n);
    n = 0;
    while (!ready && n < budget) begin tick(); n++; end
    if (!ready) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int n, w, falls;
    bit prev;
    model_reset();
    @(negedge refclk);
    tick(); tick();
    rst = 1'b0;

    // Clean lock 10 cycles after release.
    repeat (10) tick();
    locked_in = 1'b1;
    wait_ready("s1", 50, n);
    chk("s1_lock_to_ready", n, 11);
    chk("s1_retry", retry_cnt, 0);

    // One-cycle lock drop in RUN.
    locked_in = 1'b0; tick(); n = 1; locked_in = 1'b1;
    while (!sys_reset && n < 10) begin tick(); n++; end
    chk("s4_loss_latency", n, 3);
    w = 0;
    while (pll_rst && w < 20) begin w++; tick(); end
    chk("s4_pulse_len", w, RP);
`ifdef PLL_LOSS_COUNT_EN
    chk("s4_loss_cnt", loss_cnt, 1);
`endif
    wait_ready("s4_relock", 50, n);

    // Reset mid-RUN, then lock glitch 5 high / 3 low before holding high.
    repeat (3) tick();
    arst();
    locked_in = 1'b0;
    repeat (6) tick();
    locked_in = 1'b1; repeat (5) tick();
    locked_in = 1'b0; repeat (3) tick();
    locked_in = 1'b1;
    wait_ready("s3", 50, n);
    chk("s3_retry", retry_cnt, 0);

    // Reset mid-STABLE.
    arst();
    n = 0;
    while (ph != P_STB && n < 50) begin tick(); n++; end
    chk("s6_reached_stable", ph, P_STB);
    repeat (3) tick();
    arst();

    // No lock at all: three attempts then FAIL.
    locked_in = 1'b0;
    arst();
    n = 0; falls = 0; prev = pll_rst;
    while (!fail && n < 1000) begin
      tick(); n++;
      if (prev && !pll_rst) falls++;
      prev = pll_rst;
    end
    chk("s2_cycles_to_fail", n, 3 * (RP + TO));
    chk("s2_pulses", falls, MR + 1);
    repeat (20) tick();

    // Relock request out of FAIL with lock present.
    locked_in = 1'b1;
    repeat (5) tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    chk("s5_fail_cleared", fail, 0);
    chk("s5_retry", retry_cnt, 0);
    n = 1;
    while (!ready && n < 50) begin tick(); n++; end
    chk("s5_relock_to_ready", n, RP + 2 + LS);

    // Random segments.
    repeat (60) begin
      case ($urandom_range(0, 9))
        0: begin relock_req = 1'b1; tick(); relock_req = 1'b0; end
        1: arst();
        2: begin loss_clr = 1'b1; tick(); loss_clr = 1'b0; end
        default: begin
          locked_in = ($urandom_range(0, 3) != 0);
          repeat ($urandom_range(1, 40)) tick();
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
